cache_way_select: RTL and testbench

//  Tag-lookup and replacement stage of the 4-way set-associative cache; directly upstream of the
//  4:1 way data mux. Holds per-set tag/valid arrays and true-LRU ages. Produces the 2-bit way

---
 rtl/cache_pkg.sv | 16 +
 rtl/lru_age_update.sv | 22 ++
 rtl/cache_way_select.sv | 187 ++++++++++++++++++
 tb/tb_cache_way_select.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way set-associative cache tag/replacement stage.
//   NUM_WAYS / WAY_W / AGE_W : associativity and derived widths
//   state_e                  : lookup stage state encoding
//   RESET_AGES               : per-set ages after reset/flush (way0..3 = 0,1,2,3)
package cache_pkg;
  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = 2;
  localparam int AGE_W    = 2;

  typedef enum logic [0:0] {IDLE, MISS_WAIT} state_e;

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] ages_t;

  // Packed with way3 in the MSBs: way3=3, way2=2, way1=1, way0=0.
  localparam ages_t RESET_AGES = {2'd3, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/lru_age_update.sv
// True-LRU age update for one set (combinational).
//   ages_i : current ages of the 4 ways (0 = most recent, 3 = least recent)
//   way_i  : way being accessed
//   ages_o : ages after the access; stays a permutation of {0,1,2,3}
module lru_age_update
  import cache_pkg::*;
(
  input  ages_t            ages_i,
  input  logic [WAY_W-1:0] way_i,
  output ages_t            ages_o
);
  logic [AGE_W-1:0] ref_age;

  always_comb begin
    ref_age = ages_i[way_i];
    ages_o  = ages_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way_i)        ages_o[w] = '0;
      else if (ages_i[w] < ref_age)  ages_o[w] = ages_i[w] + 2'd1;
    end
  end
endmodule

// File: rtl/cache_way_select.sv
// Tag lookup and replacement stage of a 4-way set-associative cache.
// Holds per-set tags, valid bits and true-LRU ages; emits the way select for
// the downstream data mux (hit way, or LRU victim on a miss). On a miss it
// stalls in MISS_WAIT until fill_done, then installs the latched tag.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : lookup handshake (ready only in IDLE)
//   req_idx, req_tag      : lookup set index and tag
//   flush                 : invalidate everything, highest priority
//   fill_done             : victim fill complete pulse (used in MISS_WAIT only)
//   resp_valid, hit       : one-cycle lookup result
//   way_sel               : hit way or victim way
//   hit_cnt, miss_cnt     : saturating statistics, present only with CACHE_STATS_EN
// Optional feature macro: CACHE_STATS_EN
module cache_way_select
  import cache_pkg::*;
#(
  parameter int tag_w = 8,
  parameter int idx_w = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [idx_w-1:0] req_idx,
  input  logic [tag_w-1:0] req_tag,
  input  logic             flush,
  input  logic             fill_done,
  output logic             resp_valid,
  output logic             hit,
  output logic [WAY_W-1:0] way_sel
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);
  localparam int SETS = 1 << idx_w;

  state_e                                    state_q, state_d;
  logic [SETS-1:0][NUM_WAYS-1:0][tag_w-1:0]  tag_q, tag_d;
  logic [SETS-1:0][NUM_WAYS-1:0]             valid_q, valid_d;
  ages_t [SETS-1:0]                          age_q, age_d;
  logic [idx_w-1:0]                          pend_idx_q, pend_idx_d;
  logic [tag_w-1:0]                          pend_tag_q, pend_tag_d;
  logic [WAY_W-1:0]                          pend_way_q, pend_way_d;
  logic                                      resp_valid_q, resp_valid_d;
  logic                                      hit_q, hit_d;
  logic [WAY_W-1:0]                          way_sel_q, way_sel_d;

  // Lookup on the requested set
  logic             lk_hit, lk_inv_found;
  logic [WAY_W-1:0] lk_hit_way, lk_victim, lk_inv_way, lk_lru_way;
  logic             accept;

  // Single age updater: requested set in IDLE, pending set in MISS_WAIT
  logic [idx_w-1:0] upd_idx;
  logic [WAY_W-1:0] upd_way;
  ages_t            upd_ages;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    lk_hit       = 1'b0;
    lk_hit_way   = '0;
    lk_inv_found = 1'b0;
    lk_inv_way   = '0;
    lk_lru_way   = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      // Descending scan so the lowest-index invalid way wins.
      if (!valid_q[req_idx][w]) begin
        lk_inv_found = 1'b1;
        lk_inv_way   = WAY_W'(w);
      end
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (age_q[req_idx][w] == AGE_W'(NUM_WAYS-1)) lk_lru_way = WAY_W'(w);
    end
    lk_victim = lk_inv_found ? lk_inv_way : lk_lru_way;
  end

  assign upd_idx = (state_q == IDLE) ? req_idx : pend_idx_q;
  assign upd_way = (state_q == IDLE) ? lk_hit_way : pend_way_q;

  lru_age_update u_lru (
    .ages_i (age_q[upd_idx]),
    .way_i  (upd_way),
    .ages_o (upd_ages)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    age_d        = age_q;
    pend_idx_d   = pend_idx_q;
    pend_tag_d   = pend_tag_q;
    pend_way_d   = pend_way_q;
    resp_valid_d = 1'b0;
    hit_d        = hit_q;
    way_sel_d    = way_sel_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = '0;
      for (int s = 0; s < SETS; s++) age_d[s] = RESET_AGES;
    end else if (state_q == IDLE) begin
      if (accept) begin
        resp_valid_d = 1'b1;
        hit_d        = lk_hit;
        way_sel_d    = lk_hit ? lk_hit_way : lk_victim;
        if (lk_hit) begin
          age_d[req_idx] = upd_ages;
        end else begin
          state_d    = MISS_WAIT;
          pend_idx_d = req_idx;
          pend_tag_d = req_tag;
          pend_way_d = lk_victim;
        end
      end
    end else if (fill_done) begin
      tag_d[pend_idx_q][pend_way_q]   = pend_tag_q;
      valid_d[pend_idx_q][pend_way_q] = 1'b1;
      age_d[pend_idx_q]               = upd_ages;
      state_d                         = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      valid_q      <= '0;
      for (int s = 0; s < SETS; s++) age_q[s] <= RESET_AGES;
      pend_idx_q   <= '0;
      pend_tag_q   <= '0;
      pend_way_q   <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      way_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
      pend_idx_q   <= pend_idx_d;
      pend_tag_q   <= pend_tag_d;
      pend_way_q   <= pend_way_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      way_sel_q    <= way_sel_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign hit        = hit_q;
  assign way_sel    = way_sel_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Counts follow actual responses, so a flushed request is not counted.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && !flush) begin
      if (lk_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
      if (!lk_hit && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_way_select.sv
// Directed, table-driven bench for cache_way_select. Each table row is one
// clock of stimulus with the outputs expected after that edge.
module tb_cache_way_select;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_idx = '0;
  logic [7:0] req_tag = '0;
  logic       flush = 1'b0;
  logic       fill_done = 1'b0;
  logic       resp_valid;
  logic       hit;
  logic [1:0] way_sel;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  always #5 clk = ~clk;

  cache_way_select #(.tag_w(8), .idx_w(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .req_tag    (req_tag),
    .flush      (flush),
    .fill_done  (fill_done),
    .resp_valid (resp_valid),
    .hit        (hit),
    .way_sel    (way_sel)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  typedef struct {
    logic       fl;
    logic       rv;
    logic [1:0] idx;
    logic [7:0] tag;
    logic       fd;
    logic       e_resp;
    logic       e_hit;
    logic [1:0] e_way;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic rv, input logic [1:0] idx,
                     input logic [7:0] tag, input logic fd, input logic er,
                     input logic eh, input logic [1:0] ew, input logic erdy);
    vec_t v;
    v.fl = fl; v.rv = rv; v.idx = idx; v.tag = tag; v.fd = fd;
    v.e_resp = er; v.e_hit = eh; v.e_way = ew; v.e_rdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic eh,
                          input logic [1:0] ew, input logic erdy);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(er));
    chk({tag, ".req_ready"},  32'(req_ready),  32'(erdy));
    if (er) begin
      chk({tag, ".hit"},     32'(hit),     32'(eh));
      chk({tag, ".way_sel"}, 32'(way_sel), 32'(ew));
    end
  endtask

  task automatic drive(input logic fl, input logic rv, input logic [1:0] idx,
                       input logic [7:0] tag, input logic fd);
    flush = fl; req_valid = rv; req_idx = idx; req_tag = tag; fill_done = fd;
  endtask

  initial begin
    // Miss then fill on set 1
    add(0,1,1,8'h3C,0, 1,0,0,0);
    add(0,1,1,8'h3C,0, 0,0,0,0);  // request ignored while waiting
    add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,1,8'h3C,0, 1,1,0,1);
    add(0,1,1,8'h3C,0, 1,1,0,1);
    // Fill set 2 with A0..A3
    add(0,1,2,8'hA0,0, 1,0,0,0); add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA1,0, 1,0,1,0); add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA2,0, 1,0,2,0); add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA3,0, 1,0,3,0); add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA0,0, 1,1,0,1);
    add(0,1,2,8'hA4,0, 1,0,1,0);  // LRU victim is way1
    add(0,0,0,8'h00,1, 0,0,0,1);
    // Back-to-back hits, then misses that follow the true LRU
    add(0,1,2,8'hA2,0, 1,1,2,1);
    add(0,1,2,8'hA3,0, 1,1,3,1);
    add(0,1,2,8'hA0,0, 1,1,0,1);
    add(0,1,2,8'hA4,0, 1,1,1,1);
    add(0,1,2,8'hA5,0, 1,0,2,0);
    add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA1,0, 1,0,3,0);
    // Flush in MISS_WAIT, then a late fill_done must not install
    add(1,0,0,8'h00,0, 0,0,0,1);
    add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,2,8'hA1,0, 1,0,0,0);
    add(1,0,0,8'h00,0, 0,0,0,1);
    add(0,1,1,8'h3C,0, 1,0,0,0);
    add(1,0,0,8'h00,0, 0,0,0,1);
    // Flush alongside a request in IDLE: no response
    add(1,1,1,8'h3C,0, 0,0,0,1);
    add(0,1,1,8'h3C,0, 1,0,0,0);
    add(0,0,0,8'h00,1, 0,0,0,1);
    add(0,1,1,8'h3C,0, 1,1,0,1);

    // Reset state
    repeat (2) @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 2'd0, 1'b1);
    chk("reset.hit", 32'(hit), 32'd0);
    chk("reset.way_sel", 32'(way_sel), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].rv, vecs[i].idx, vecs[i].tag, vecs[i].fd);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_resp, vecs[i].e_hit,
               vecs[i].e_way, vecs[i].e_rdy);
      if (vecs[i].e_resp) begin
        if (vecs[i].e_hit) exp_hits++;
        else               exp_misses++;
      end
    end

    // Miss to set 1 with way0 valid: victim way1, then async reset mid-wait
    drive(0,1,1,8'h77,0);
    @(negedge clk);
    drive(0,0,0,8'h00,0);
    chk_outs("pre_rst", 1'b1, 1'b0, 2'd1, 1'b0);
    exp_misses++;
`ifdef CACHE_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    chk("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("async_rst.req_ready",  32'(req_ready),  32'd1);
    chk("async_rst.hit",        32'(hit),        32'd0);
    chk("async_rst.way_sel",    32'(way_sel),    32'd0);
`ifdef CACHE_STATS_EN
    chk("async_rst.hit_cnt",  32'(hit_cnt),  32'd0);
    chk("async_rst.miss_cnt", 32'(miss_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // Pending fill discarded and valids cleared: a fill pulse now is ignored
    drive(0,0,0,8'h00,1);
    @(negedge clk);
    chk_outs("post_rst_fill", 1'b0, 1'b0, 2'd0, 1'b1);
    drive(0,1,1,8'h3C,0);
    @(negedge clk);
    drive(0,0,0,8'h00,0);
    chk_outs("post_rst_lookup", 1'b1, 1'b0, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
